// File: rtl/act_fetch_sched.sv
// act_fetch_sched: fetches activation blocks from the distributor on demand and
// hands each block to one of NUM_REQ consumers in round-robin order.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   cfg_start, cfg_num_blk start pulse and block count of a tile
//   sw_clr                 synchronous abort back to idle
//   req, gnt, get          consumer request level, one-hot grant level, take pulse
//   fetch_pls, act_rdy     fetch pulse to distributor, distributor block-ready level
//   busy, done, blk_cnt    tile active, last-block-taken pulse, blocks delivered
module act_fetch_sched #(
  parameter int NUM_REQ       = 4,
  parameter int BLK_CNT_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_start,
  input  logic [BLK_CNT_WIDTH-1:0] cfg_num_blk,
  input  logic                     sw_clr,
  input  logic [NUM_REQ-1:0]       req,
  output logic [NUM_REQ-1:0]       gnt,
  input  logic [NUM_REQ-1:0]       get,
  output logic                     fetch_pls,
  input  logic                     act_rdy,
  output logic                     busy,
  output logic                     done,
  output logic [BLK_CNT_WIDTH-1:0] blk_cnt
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARB   = 3'd1;
  localparam logic [2:0] FETCH = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] GRANT = 3'd4;

  logic [2:0]               state;
  logic [IW-1:0]            rrPtr;
  logic [IW-1:0]            winner;
  logic [IW-1:0]            pick;
  logic [IW-1:0]            idx;
  logic [BLK_CNT_WIDTH-1:0] numReg;
  logic [BLK_CNT_WIDTH-1:0] nextCnt;

  // Scan downward so the last hit kept is the first requester after rrPtr.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(rrPtr) + k) % NUM_REQ);
      if (req[idx]) pick = idx;
    end
  end

  assign nextCnt   = blk_cnt + BLK_CNT_WIDTH'(1);
  assign gnt       = (state == GRANT) ? (NUM_REQ'(1) << winner) : '0;
  assign fetch_pls = (state == FETCH);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rrPtr   <= IW'(NUM_REQ - 1);
      winner  <= '0;
      numReg  <= '0;
      blk_cnt <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (sw_clr) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (cfg_start) begin
            if (cfg_num_blk != '0) begin
              numReg  <= cfg_num_blk;
              blk_cnt <= '0;
              state   <= ARB;
            end else begin
              done <= 1'b1;
            end
          end
          ARB: if (|req) begin
            winner <= pick;
            state  <= FETCH;
          end
          FETCH: state <= WAIT;
          WAIT: if (act_rdy) state <= GRANT;
          GRANT: if (get[winner]) begin
            blk_cnt <= nextCnt;
            rrPtr   <= winner;
            done    <= (nextCnt == numReg);
            state   <= (nextCnt == numReg) ? IDLE : ARB;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_act_fetch_sched.sv
// tb_act_fetch_sched: directed scoreboard bench for act_fetch_sched.
// Expected grant winners are queued when a tile is configured and popped as
// each grant appears; the bench plays both distributor and consumers.
module tb_act_fetch_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [11:0] cfg_num_blk = '0;
  logic        sw_clr = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  gnt;
  logic [3:0]  get = '0;
  logic        fetch_pls;
  logic        act_rdy = 1'b0;
  logic        busy;
  logic        done;
  logic [11:0] blk_cnt;

  int tests = 0;
  int fails = 0;
  int fetches = 0;
  int expQ[$];

  act_fetch_sched #(.NUM_REQ(4), .BLK_CNT_WIDTH(12)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_num_blk(cfg_num_blk),
    .sw_clr(sw_clr), .req(req), .gnt(gnt), .get(get), .fetch_pls(fetch_pls),
    .act_rdy(act_rdy), .busy(busy), .done(done), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; get = '0; act_rdy = 1'b0; cfg_start = 1'b0; sw_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    expQ.delete();
    fetches = 0;
  endtask

  task automatic startTile(input int num);
    @(negedge clk);
    cfg_num_blk = 12'(num); cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic waitFetch();
    int t = 0;
    while (fetch_pls !== 1'b1 && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk("fetch_seen", fetch_pls, 1);
    if (fetch_pls === 1'b1) fetches++;
  endtask

  // One full block: fetch pulse, ready two cycles after it, grant, take.
  task automatic serveBlock(input int k, input int num, input int getDelay, input bit dropReq);
    int w;
    waitFetch();
    chk("gnt_in_fetch", gnt, 0);
    @(negedge clk);
    chk("single_pulse", fetch_pls, 0);
    @(negedge clk);
    act_rdy = 1'b1;
    @(negedge clk);
    w = (expQ.size() > 0) ? expQ.pop_front() : -1;
    chk("gnt_winner", gnt, (w >= 0) ? (32'd1 << w) : 32'd0);
    if (dropReq && w >= 0) begin
      req[w] = 1'b0;
      @(negedge clk);
      chk("gnt_held_after_drop", gnt, 32'd1 << w);
    end
    for (int d = 0; d < getDelay; d++) begin
      get = (d == 0) ? ~gnt : 4'b0000;
      @(negedge clk);
      get = 4'b0000;
      chk("stray_get_ignored", blk_cnt, k - 1);
    end
    get = gnt;
    @(negedge clk);
    get = 4'b0000;
    act_rdy = 1'b0;
    chk("blk_cnt", blk_cnt, k);
    chk("done", done, (k == num) ? 1 : 0);
    chk("busy", busy, (k == num) ? 0 : 1);
    chk("gnt_off", gnt, 0);
  endtask

  initial begin
    #2;
    chk("rst_gnt", gnt, 0);
    chk("rst_fetch", fetch_pls, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_blk_cnt", blk_cnt, 0);

    // T1: single requester, three blocks
    doReset();
    req = 4'b0001;
    expQ = '{0, 0, 0};
    startTile(3);
    for (int k = 1; k <= 3; k++) serveBlock(k, 3, 0, 1'b0);
    chk("t1_fetch_count", fetches, 3);
    @(negedge clk);
    chk("t1_done_pulse_ends", done, 0);
    chk("t1_idle_keeps_cnt", blk_cnt, 3);

    // T2: all requesting, rotate 0..3 twice; a start while busy is ignored
    doReset();
    req = 4'b1111;
    expQ = '{0, 1, 2, 3, 0, 1, 2, 3};
    startTile(8);
    for (int k = 1; k <= 8; k++) begin
      if (k == 4) begin
        cfg_num_blk = 12'd1; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
      end
      serveBlock(k, 8, (k == 2) ? 2 : 0, 1'b0);
    end
    chk("t2_fetch_count", fetches, 8);
    chk("t2_queue_empty", expQ.size(), 0);

    // T3: requesters 0 and 2 alternate
    doReset();
    req = 4'b0101;
    expQ = '{0, 2, 0, 2};
    startTile(4);
    for (int k = 1; k <= 4; k++) serveBlock(k, 4, 1, 1'b0);
    chk("t3_fetch_count", fetches, 4);

    // T4: winner drops req while granted; no further fetch until a new request
    doReset();
    req = 4'b0100;
    expQ = '{2, 1};
    startTile(2);
    serveBlock(1, 2, 1, 1'b1);
    repeat (5) @(negedge clk);
    chk("t4_no_extra_fetch", fetches, 1);
    chk("t4_fetch_idle", fetch_pls, 0);
    chk("t4_still_busy", busy, 1);
    req = 4'b0010;
    serveBlock(2, 2, 0, 1'b0);
    chk("t4_fetch_count", fetches, 2);

    // T5: empty tile
    doReset();
    @(negedge clk);
    cfg_num_blk = 12'd0; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("t5_done", done, 1);
    chk("t5_busy", busy, 0);
    chk("t5_fetch", fetch_pls, 0);
    @(negedge clk);
    chk("t5_done_ends", done, 0);
    chk("t5_fetch_later", fetch_pls, 0);

    // T6: abort while waiting on the distributor, then a fresh tile of two
    doReset();
    req = 4'b0001;
    startTile(3);
    waitFetch();
    @(negedge clk);
    sw_clr = 1'b1;
    @(negedge clk);
    sw_clr = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_no_done", done, 0);
    chk("t6_gnt", gnt, 0);
    chk("t6_cnt_kept", blk_cnt, 0);
    @(negedge clk);
    chk("t6_no_done_later", done, 0);
    fetches = 0;
    expQ = '{0, 0};
    startTile(2);
    for (int k = 1; k <= 2; k++) serveBlock(k, 2, 0, 1'b0);
    chk("t6_fetch_count", fetches, 2);

    // T7: asynchronous reset while a grant is up
    doReset();
    req = 4'b0010;
    expQ = '{1};
    startTile(1);
    waitFetch();
    @(negedge clk);
    @(negedge clk);
    act_rdy = 1'b1;
    @(negedge clk);
    chk("t7_gnt", gnt, 32'd1 << expQ.pop_front());
    #2 rst_n = 1'b0;
    #1;
    chk("t7_async_gnt", gnt, 0);
    chk("t7_async_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    act_rdy = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
